// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds, sticky
// overflow/underflow flags and a selectable registered or show-ahead read port.
module sync_fifo_prog #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
    parameter int unsigned FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  write_en,
    input  logic                  read_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic [ADDR_WIDTH:0]   ae_thresh,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0]   CountMax = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CountOne = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PtrOne   = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  rd_acc, wr_acc;

    assign full         = (count_q == CountMax);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= af_thresh);
    assign almost_empty = (count_q <= ae_thresh);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    assign rd_acc = read_en && !empty;
    assign wr_acc = write_en && (!full || rd_acc);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CountOne;
            2'b01:   count_d = count_q - CountOne;
            default: count_d = count_q;
        endcase
    end

    // Set beats clear when both happen in one cycle.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (write_en && !wr_acc) begin
            overflow_d = 1'b1;
        end
        if (read_en && !rd_acc) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign data_out = mem_q[rd_ptr_q];
        assign valid    = !empty;
    end else begin : g_reg
        logic [DATA_WIDTH-1:0] dout_q, dout_d;
        logic                  valid_q;

        always_comb begin
            dout_d = dout_q;
            if (rd_acc) begin
                dout_d = mem_q[rd_ptr_q];
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                dout_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                dout_q  <= dout_d;
                valid_q <= rd_acc;
            end
        end

        assign data_out = dout_q;
        assign valid    = valid_q;
    end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Drives a registered-read and a show-ahead instance with identical stimulus and
// compares both against a queue-based model of the FIFO.
module tb_sync_fifo_prog;

    localparam int unsigned Dw    = 16;
    localparam int unsigned Depth = 8;
    localparam int unsigned Aw    = $clog2(Depth);

    logic          clk;
    logic          reset_n;
    logic          write_en, read_en, clr_err;
    logic [Dw-1:0] data_in;
    logic [Aw:0]   af_thresh, ae_thresh;

    logic [Dw-1:0] r_dout, f_dout;
    logic          r_valid, f_valid;
    logic [Aw:0]   r_count, f_count;
    logic          r_full, f_full, r_empty, f_empty;
    logic          r_af, f_af, r_ae, f_ae;
    logic          r_ovf, f_ovf, r_unf, f_unf;

    sync_fifo_prog #(.DATA_WIDTH(Dw), .DEPTH(Depth), .FWFT(0)) u_dut_reg (
        .clk(clk), .reset_n(reset_n), .write_en(write_en), .read_en(read_en),
        .data_in(data_in), .af_thresh(af_thresh), .ae_thresh(ae_thresh), .clr_err(clr_err),
        .data_out(r_dout), .valid(r_valid), .count(r_count), .full(r_full), .empty(r_empty),
        .almost_full(r_af), .almost_empty(r_ae), .overflow(r_ovf), .underflow(r_unf)
    );

    sync_fifo_prog #(.DATA_WIDTH(Dw), .DEPTH(Depth), .FWFT(1)) u_dut_fwft (
        .clk(clk), .reset_n(reset_n), .write_en(write_en), .read_en(read_en),
        .data_in(data_in), .af_thresh(af_thresh), .ae_thresh(ae_thresh), .clr_err(clr_err),
        .data_out(f_dout), .valid(f_valid), .count(f_count), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .overflow(f_ovf), .underflow(f_unf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state
    logic [Dw-1:0] exp_q[$];
    logic [Dw-1:0] exp_dout;
    logic          exp_valid, exp_ovf, exp_unf;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string ctx);
        int cnt;
        cnt = exp_q.size();
        check({ctx, " r_count"}, 32'(r_count), 32'(cnt));
        check({ctx, " f_count"}, 32'(f_count), 32'(cnt));
        check({ctx, " r_full"},  32'(r_full),  32'(cnt == Depth));
        check({ctx, " f_full"},  32'(f_full),  32'(cnt == Depth));
        check({ctx, " r_empty"}, 32'(r_empty), 32'(cnt == 0));
        check({ctx, " f_empty"}, 32'(f_empty), 32'(cnt == 0));
        check({ctx, " r_af"},    32'(r_af),    32'(cnt >= int'(af_thresh)));
        check({ctx, " f_af"},    32'(f_af),    32'(cnt >= int'(af_thresh)));
        check({ctx, " r_ae"},    32'(r_ae),    32'(cnt <= int'(ae_thresh)));
        check({ctx, " f_ae"},    32'(f_ae),    32'(cnt <= int'(ae_thresh)));
        check({ctx, " r_ovf"},   32'(r_ovf),   32'(exp_ovf));
        check({ctx, " f_ovf"},   32'(f_ovf),   32'(exp_ovf));
        check({ctx, " r_unf"},   32'(r_unf),   32'(exp_unf));
        check({ctx, " f_unf"},   32'(f_unf),   32'(exp_unf));
        check({ctx, " r_valid"}, 32'(r_valid), 32'(exp_valid));
        check({ctx, " r_dout"},  32'(r_dout),  32'(exp_dout));
        check({ctx, " f_valid"}, 32'(f_valid), 32'(cnt != 0));
        if (cnt != 0) begin
            check({ctx, " f_dout"}, 32'(f_dout), 32'(exp_q[0]));
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        exp_dout  = '0;
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
        exp_unf   = 1'b0;
    endtask

    task automatic model_update(input logic we, input logic re, input logic [Dw-1:0] din,
                                input logic clr);
        bit rd_ok, wr_ok;
        rd_ok = re && (exp_q.size() > 0);
        wr_ok = we && ((exp_q.size() < Depth) || rd_ok);
        exp_valid = rd_ok;
        if (rd_ok) exp_dout = exp_q.pop_front();
        if (wr_ok) exp_q.push_back(din);
        exp_ovf = (we && !wr_ok) ? 1'b1 : (clr ? 1'b0 : exp_ovf);
        exp_unf = (re && !rd_ok) ? 1'b1 : (clr ? 1'b0 : exp_unf);
    endtask

    // Entered just after a rising edge; leaves just after the next one.
    task automatic step(input string ctx, input logic we, input logic re,
                        input logic [Dw-1:0] din, input logic clr);
        write_en = we;
        read_en  = re;
        data_in  = din;
        clr_err  = clr;
        #3;
        check_all(ctx);
        @(posedge clk);
        model_update(we, re, din, clr);
        #1;
    endtask

    task automatic idle(input string ctx);
        step(ctx, 1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        reset_n   = 1'b1;
        write_en  = 1'b0;
        read_en   = 1'b0;
        clr_err   = 1'b0;
        data_in   = '0;
        af_thresh = (Aw + 1)'(6);
        ae_thresh = (Aw + 1)'(2);
        model_clear();
        #1 reset_n = 1'b0;
        #1 check_all("reset");
        @(posedge clk);
        @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill and drain, stepping thresholds through every occupancy
        for (int i = 1; i <= 8; i++) step("fill", 1'b1, 1'b0, 16'(i), 1'b0);
        idle("full8");
        af_thresh = (Aw + 1)'(9);
        #1;
        check("af9 r_af", 32'(r_af), 32'(0));
        check("af9 f_af", 32'(f_af), 32'(0));
        af_thresh = (Aw + 1)'(6);
        for (int i = 0; i < 8; i++) step("drain", 1'b0, 1'b1, '0, 1'b0);
        idle("drained");

        // Simultaneous read/write while full
        for (int i = 1; i <= 8; i++) step("refill", 1'b1, 1'b0, 16'(16'h10 + i), 1'b0);
        step("full_rw", 1'b1, 1'b1, 16'hAAAA, 1'b0);
        idle("full_rw_after");
        for (int i = 0; i < 8; i++) step("drain2", 1'b0, 1'b1, '0, 1'b0);
        idle("drained2");

        // Sticky error flags
        for (int i = 1; i <= 8; i++) step("efill", 1'b1, 1'b0, 16'(16'h20 + i), 1'b0);
        step("ovf", 1'b1, 1'b0, 16'hDEAD, 1'b0);
        for (int i = 0; i < 8; i++) step("edrain", 1'b0, 1'b1, '0, 1'b0);
        step("unf", 1'b0, 1'b1, '0, 1'b0);
        step("empty_rw", 1'b1, 1'b1, 16'h1234, 1'b0);
        idle("hold1");
        idle("hold2");
        step("clr", 1'b0, 1'b0, '0, 1'b1);
        idle("cleared");
        for (int i = 1; i <= 7; i++) step("cfill", 1'b1, 1'b0, 16'(16'h30 + i), 1'b0);
        step("ovf_clr", 1'b1, 1'b0, 16'hBEEF, 1'b1);
        idle("ovf_clr_after");
        step("clr2", 1'b0, 1'b0, '0, 1'b1);

        // Show-ahead write into empty, then pop
        for (int i = 0; i < 8; i++) step("fdrain", 1'b0, 1'b1, '0, 1'b0);
        step("fwft_wr", 1'b1, 1'b0, 16'h1234, 1'b0);
        idle("fwft_show");
        step("fwft_pop", 1'b0, 1'b1, '0, 1'b0);
        idle("fwft_popped");

        // Randomized traffic with drifting read/write bias
        for (int i = 0; i < 600; i++) begin
            int wbias;
            logic we, re, clr;
            wbias = ((i / 40) % 3 == 0) ? 80 : (((i / 40) % 3 == 1) ? 25 : 55);
            if (i % 37 == 0) begin
                af_thresh = (Aw + 1)'($urandom_range(0, 15));
                ae_thresh = (Aw + 1)'($urandom_range(0, 15));
            end
            we  = ($urandom_range(0, 99) < wbias);
            re  = ($urandom_range(0, 99) < (100 - wbias));
            clr = ($urandom_range(0, 15) == 0);
            step("rand", we, re, 16'($urandom), clr);
        end

        // Reset between edges with words stored
        af_thresh = (Aw + 1)'(6);
        ae_thresh = (Aw + 1)'(2);
        for (int i = 0; i < 8; i++) step("pre_drain", 1'b0, 1'b1, '0, 1'b0);
        for (int i = 1; i <= 5; i++) step("load5", 1'b1, 1'b0, 16'(16'h50 + i), 1'b0);
        step("pop1", 1'b0, 1'b1, '0, 1'b0);
        write_en = 1'b0;
        read_en  = 1'b0;
        clr_err  = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        model_clear();
        check_all("midrst");
        @(posedge clk);
        #3 check_all("midrst_hold");
        @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        step("post_wr", 1'b1, 1'b0, 16'h00FF, 1'b0);
        step("post_rd", 1'b0, 1'b1, '0, 1'b0);
        idle("post_show");
        check("post r_dout", 32'(r_dout), 32'h00FF);
        idle("end");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
